// File: rtl/reorder_status_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_pkg
// Description : Shared types and constants for the reorder status table:
//               2-bit per-tag status encoding and the default tag width.
// Revision    : 1.0 - initial release
// ============================================================================
package reorder_pkg;

    // Default width of a reorder tag
    localparam int TAG_WIDTH_DEFAULT = 6;

    // Per-tag status
    typedef logic [1:0] status_t;

    localparam status_t ST_FREE     = 2'b00;
    localparam status_t ST_PENDING  = 2'b01;
    localparam status_t ST_REJECTED = 2'b10;
    localparam status_t ST_ACCEPTED = 2'b11;

    // A tag is resolved once a core has delivered its verdict
    function automatic logic is_resolved(input status_t st);
        return (st == ST_REJECTED) || (st == ST_ACCEPTED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_status_table_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_status_table_if
// Description : Bus bundle of the reorder status table: tag allocation,
//               per-core verdict writes, emit handshake and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_status_table_if
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int NUM_CORES = 4
);

    logic                           alloc_valid;
    logic                           alloc_ready;
    logic [TAG_WIDTH-1:0]           alloc_tag;
    logic [NUM_CORES-1:0]           bpf_wr_valid;
    logic [NUM_CORES*TAG_WIDTH-1:0] bpf_wr_tag;
    logic [NUM_CORES-1:0]           bpf_wr_accept;
    logic                           emit_valid;
    logic                           emit_ready;
    logic [TAG_WIDTH-1:0]           emit_tag;
    logic                           emit_accept;
    logic [TAG_WIDTH:0]             occupancy;
    logic                           err_dup_write;
    logic                           err_unalloc_write;

    // Environment side: ingress, BPF cores and circular buffer
    modport master (
        output alloc_valid, bpf_wr_valid, bpf_wr_tag, bpf_wr_accept, emit_ready,
        input  alloc_ready, alloc_tag, emit_valid, emit_tag, emit_accept,
               occupancy, err_dup_write, err_unalloc_write
    );

    // Table side
    modport slave (
        input  alloc_valid, bpf_wr_valid, bpf_wr_tag, bpf_wr_accept, emit_ready,
        output alloc_ready, alloc_tag, emit_valid, emit_tag, emit_accept,
               occupancy, err_dup_write, err_unalloc_write
    );

endinterface
`default_nettype wire

// File: rtl/reorder_status_table_status_write_resolve.sv
`default_nettype none
// ============================================================================
// Module      : status_write_resolve
// Description : Combinational resolution of the per-core verdict writes.
//               Lower core index has priority on a shared tag; produces
//               per-entry write enables/new states and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module status_write_resolve
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int DEPTH     = 50,
    parameter int NUM_CORES = 4
) (
    input  wire logic [NUM_CORES-1:0]           i_wr_valid,
    input  wire logic [NUM_CORES*TAG_WIDTH-1:0] i_wr_tag,
    input  wire logic [NUM_CORES-1:0]           i_wr_accept,
    input  wire status_t [DEPTH-1:0]            i_entry_state,
    output logic [DEPTH-1:0]                    o_entry_we,
    output status_t [DEPTH-1:0]                 o_entry_new,
    output logic                                o_err_dup,
    output logic                                o_err_unalloc
);

    logic [DEPTH-1:0]     w_claimed;
    logic                 w_hit;
    logic [TAG_WIDTH-1:0] w_tag;

    // Walk cores in priority order; a tag claimed by an earlier core turns
    // every later writer to the same tag into a duplicate. A tag that matches
    // no entry index is out of range and counts as unallocated.
    always_comb begin
        o_entry_we    = '0;
        o_entry_new   = i_entry_state;
        o_err_dup     = 1'b0;
        o_err_unalloc = 1'b0;
        w_claimed     = '0;
        w_hit         = 1'b0;
        w_tag         = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_tag = i_wr_tag[c*TAG_WIDTH +: TAG_WIDTH];
            w_hit = 1'b0;
            if (i_wr_valid[c]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (w_tag == TAG_WIDTH'(e)) begin
                        w_hit = 1'b1;
                        if (w_claimed[e]) begin
                            o_err_dup = 1'b1;
                        end else if (i_entry_state[e] == ST_FREE) begin
                            o_err_unalloc = 1'b1;
                        end else if (is_resolved(i_entry_state[e])) begin
                            o_err_dup = 1'b1;
                        end else begin
                            o_entry_we[e]  = 1'b1;
                            o_entry_new[e] = i_wr_accept[c] ? ST_ACCEPTED : ST_REJECTED;
                            w_claimed[e]   = 1'b1;
                        end
                    end
                end
                if (!w_hit) begin
                    o_err_unalloc = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_status_table.sv
`default_nettype none
// ============================================================================
// Module      : reorder_status_table
// Description : Reorder status table. Tags are allocated in arrival order,
//               verdicts arrive from NUM_CORES cores in any order, and are
//               released through a valid/ready emit port strictly in tag
//               order. Tracks occupancy and sticky write errors.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_status_table
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int DEPTH     = 50,
    parameter int NUM_CORES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    reorder_status_table_if.slave  bus
);

    localparam int                   c_OCC_W    = TAG_WIDTH + 1;
    localparam logic [c_OCC_W-1:0]   c_DEPTH    = c_OCC_W'(DEPTH);
    localparam logic [TAG_WIDTH-1:0] c_LAST_TAG = TAG_WIDTH'(DEPTH - 1);

    status_t [DEPTH-1:0]  entry_q, entry_d;
    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [c_OCC_W-1:0]   occupancy_q, occupancy_d;
    logic                 err_dup_q, err_dup_d;
    logic                 err_unalloc_q, err_unalloc_d;

    status_t              w_head_state;
    logic                 w_alloc_ready;
    logic                 w_alloc_fire;
    logic                 w_emit_valid;
    logic                 w_emit_fire;
    logic [DEPTH-1:0]     w_entry_we;
    status_t [DEPTH-1:0]  w_entry_new;
    logic                 w_err_dup;
    logic                 w_err_unalloc;

    status_write_resolve #(
        .TAG_WIDTH (TAG_WIDTH),
        .DEPTH     (DEPTH),
        .NUM_CORES (NUM_CORES)
    ) u_resolve (
        .i_wr_valid    (bus.bpf_wr_valid),
        .i_wr_tag      (bus.bpf_wr_tag),
        .i_wr_accept   (bus.bpf_wr_accept),
        .i_entry_state (entry_q),
        .o_entry_we    (w_entry_we),
        .o_entry_new   (w_entry_new),
        .o_err_dup     (w_err_dup),
        .o_err_unalloc (w_err_unalloc)
    );

    // Handshake qualifiers; all derived from registered state so a freed slot
    // or a fresh verdict only becomes visible the following cycle.
    always_comb begin
        w_head_state = ST_FREE;
        for (int e = 0; e < DEPTH; e++) begin
            if (head_q == TAG_WIDTH'(e)) begin
                w_head_state = entry_q[e];
            end
        end
        w_alloc_ready = !rst && (occupancy_q != c_DEPTH);
        w_emit_valid  = !rst && (occupancy_q != '0) && is_resolved(w_head_state);
        w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
        w_emit_fire   = w_emit_valid && bus.emit_ready;
    end

    assign bus.alloc_ready       = w_alloc_ready;
    assign bus.alloc_tag         = tail_q;
    assign bus.emit_valid        = w_emit_valid;
    assign bus.emit_tag          = head_q;
    assign bus.emit_accept       = (w_head_state == ST_ACCEPTED);
    assign bus.occupancy         = occupancy_q;
    assign bus.err_dup_write     = err_dup_q;
    assign bus.err_unalloc_write = err_unalloc_q;

    // Next-state: verdict writes first, then the emit frees the head, then
    // the alloc marks the tail pending (so alloc+write on one tag ends PENDING).
    always_comb begin
        entry_d = entry_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_entry_we[e]) begin
                entry_d[e] = w_entry_new[e];
            end
            if (w_emit_fire && (head_q == TAG_WIDTH'(e))) begin
                entry_d[e] = ST_FREE;
            end
            if (w_alloc_fire && (tail_q == TAG_WIDTH'(e))) begin
                entry_d[e] = ST_PENDING;
            end
        end

        head_d = head_q;
        if (w_emit_fire) begin
            head_d = (head_q == c_LAST_TAG) ? '0 : head_q + 1'b1;
        end

        tail_d = tail_q;
        if (w_alloc_fire) begin
            tail_d = (tail_q == c_LAST_TAG) ? '0 : tail_q + 1'b1;
        end

        occupancy_d = occupancy_q;
        case ({w_alloc_fire, w_emit_fire})
            2'b10:   occupancy_d = occupancy_q + 1'b1;
            2'b01:   occupancy_d = occupancy_q - 1'b1;
            default: occupancy_d = occupancy_q;
        endcase

        err_dup_d     = err_dup_q     || w_err_dup;
        err_unalloc_d = err_unalloc_q || w_err_unalloc;
    end

    // State registers; reset discards every in-flight tag
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            occupancy_q   <= '0;
            err_dup_q     <= 1'b0;
            err_unalloc_q <= 1'b0;
        end else begin
            entry_q       <= entry_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            occupancy_q   <= occupancy_d;
            err_dup_q     <= err_dup_d;
            err_unalloc_q <= err_unalloc_d;
        end
    end

endmodule
`default_nettype wire
